mp_add_seq: RTL

MP_ADD_SEQ -- requirements
Module: mp_add_seq

---
 rtl/mp_add_seq_pkg.sv | 33 +++
 rtl/mp_add_seq_cla.sv | 50 +++++
 rtl/mp_add_seq.sv | 137 +++++++++++++
 3 files changed

// File: rtl/mp_add_seq_pkg.sv
// Shared ALU package for the multi-precision sequential adder.
// Holds the limb width, the controller state encoding and the 4-bit
// carry-lookahead helper used by the 16-bit limb adder.
package mp_add_seq_pkg;

    localparam int LIMB_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Carries out of each bit of a 4-bit lookahead group, given the
    // per-bit generate/propagate terms and the carry into the group.
    // Bit 3 of the result is the carry out of the whole group.
    function automatic logic [3:0] cla4_carries(
        input logic [3:0] g,
        input logic [3:0] p,
        input logic       c0
    );
        logic [3:0] c;
        c[0] = g[0] | (p[0] & c0);
        c[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
        c[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & c0);
        c[3] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c0);
        return c;
    endfunction

endpackage

// File: rtl/mp_add_seq_cla.sv
// CLA_16bit: purely combinational 16-bit carry-lookahead adder built as
// two levels of 4-bit lookahead (bit level inside each nibble, group level
// across the four nibbles). Used once per limb by mp_add_seq.
module CLA_16bit
    import mp_add_seq_pkg::*;
(
    input  logic [15:0] A,
    input  logic [15:0] B,
    input  logic        Cin,
    output logic [15:0] Sum,
    output logic        Cout
);

    logic [15:0] g;
    logic [15:0] p;
    logic [3:0]  gg;
    logic [3:0]  gp;
    logic [3:0]  bc;
    logic [3:0]  blk_cin;
    logic [16:0] carry;

    // Group generate/propagate, group carries, then bit carries and sum.
    always_comb begin
        logic [3:0] t;
        t       = '0;
        g       = A & B;
        p       = A ^ B;
        gg      = '0;
        gp      = '0;
        carry   = '0;
        for (int k = 0; k < 4; k++) begin
            t     = cla4_carries(g[4*k +: 4], p[4*k +: 4], 1'b0);
            gg[k] = t[3];
            gp[k] = &p[4*k +: 4];
        end
        bc      = cla4_carries(gg, gp, Cin);
        blk_cin = {bc[2:0], Cin};
        carry[0] = Cin;
        for (int k = 0; k < 4; k++) begin
            t              = cla4_carries(g[4*k +: 4], p[4*k +: 4], blk_cin[k]);
            carry[4*k + 1] = t[0];
            carry[4*k + 2] = t[1];
            carry[4*k + 3] = t[2];
            carry[4*k + 4] = bc[k];
        end
        Sum  = p ^ carry[15:0];
        Cout = carry[16];
    end

endmodule

// File: rtl/mp_add_seq.sv
// mp_add_seq: multi-precision adder that processes one 16-bit limb per
// clock through a single CLA_16bit, least-significant limb first.
// Handshake: valid/ready on the operand side and on the result side.
// The result is held in DONE until the consumer takes it.
module mp_add_seq #(
    parameter int NLIMBS = 4,
    parameter int LIMB_W = mp_add_seq_pkg::LIMB_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NLIMBS*LIMB_W-1:0] op_a,
    input  logic [NLIMBS*LIMB_W-1:0] op_b,
    input  logic                     cin,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NLIMBS*LIMB_W-1:0] sum,
    output logic                     cout,
    output logic                     ovf,
    output logic                     busy,
    output logic                     limb_en
);
    import mp_add_seq_pkg::*;

    // Only LIMB_W = 16 is meaningful: the limb adder is fixed at 16 bits.
    localparam int TOTAL_W = NLIMBS * LIMB_W;
    localparam int IDX_W   = (NLIMBS > 1) ? $clog2(NLIMBS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NLIMBS - 1);

    state_t             state_q;
    state_t             state_d;

    logic [TOTAL_W-1:0] a_q;
    logic [TOTAL_W-1:0] b_q;
    logic [TOTAL_W-1:0] sum_q;
    logic               carry_q;
    logic               ovf_q;
    logic [IDX_W-1:0]   idx_q;

    logic [LIMB_W-1:0]  limb_a;
    logic [LIMB_W-1:0]  limb_b;
    logic [LIMB_W-1:0]  limb_sum;
    logic               limb_cout;
    logic               accept;
    logic               last_limb;

    assign limb_a    = a_q[idx_q*LIMB_W +: LIMB_W];
    assign limb_b    = b_q[idx_q*LIMB_W +: LIMB_W];
    assign accept    = (state_q == ST_IDLE) && in_valid;
    assign last_limb = (idx_q == LAST_IDX);

    CLA_16bit u_cla (
        .A    (limb_a),
        .B    (limb_b),
        .Cin  (carry_q),
        .Sum  (limb_sum),
        .Cout (limb_cout)
    );

    // Controller state register; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and handshake/status outputs decoded from state.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        limb_en   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                busy    = 1'b1;
                limb_en = 1'b1;
                if (last_limb) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Operand capture on accept, then one limb add per RUN cycle; overflow
    // is judged on the top limb, where the sum sign bit is produced.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            idx_q   <= '0;
        end else if (accept) begin
            a_q     <= op_a;
            b_q     <= op_b;
            sum_q   <= '0;
            carry_q <= cin;
            ovf_q   <= 1'b0;
            idx_q   <= '0;
        end else if (state_q == ST_RUN) begin
            sum_q[idx_q*LIMB_W +: LIMB_W] <= limb_sum;
            carry_q <= limb_cout;
            if (last_limb) begin
                ovf_q <= (a_q[TOTAL_W-1] == b_q[TOTAL_W-1])
                      && (limb_sum[LIMB_W-1] != a_q[TOTAL_W-1]);
            end else begin
                idx_q <= idx_q + 1'b1;
            end
        end
    end

    assign sum  = sum_q;
    assign cout = carry_q;
    assign ovf  = ovf_q;

endmodule
